usr_seq_nb: RTL

USR_SEQ_NB -- requirements
Module: usr_seq_nb

---
 rtl/usr_seq_nb.sv | 137 +++++++++++++
 1 files changed

// File: rtl/usr_seq_nb.sv
// Multi-cycle universal shift register: load/clear/hold in one edge, shifts one bit per edge.
// Optional carry-out register is built when USR_SEQ_CARRY_EN is defined.
module usr_seq_nb #(
  parameter int unsigned N  = 8,
  parameter int unsigned AW = 3
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          start,
  input  logic [2:0]    op,
  input  logic [AW-1:0] amt,
  input  logic [N-1:0]  data_in,
  input  logic          dbit,
  output logic [N-1:0]  data_out,
  output logic          busy,
  output logic          done
`ifdef USR_SEQ_CARRY_EN
  ,
  output logic          carry
`endif
);

  localparam logic [2:0] OpHold = 3'd0;
  localparam logic [2:0] OpLoad = 3'd1;
  localparam logic [2:0] OpShl  = 3'd2;
  localparam logic [2:0] OpShr  = 3'd3;
  localparam logic [2:0] OpRol  = 3'd4;
  localparam logic [2:0] OpRor  = 3'd5;
  localparam logic [2:0] OpAsr  = 3'd6;
  localparam logic [2:0] OpClr  = 3'd7;

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [2:0]    op_q, op_d;
  logic [N-1:0]  data_q, data_d;
  logic          done_q, done_d;

  function automatic logic [N-1:0] step(input logic [2:0] o, input logic [N-1:0] d,
                                        input logic fill);
    case (o)
      OpShl:   step = {d[N-2:0], fill};
      OpShr:   step = {fill, d[N-1:1]};
      OpRol:   step = {d[N-2:0], d[N-1]};
      OpRor:   step = {d[0], d[N-1:1]};
      OpAsr:   step = {d[N-1], d[N-1:1]};
      default: step = d;
    endcase
  endfunction

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= OpHold;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    data_d  = data_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          unique case (op)
            OpHold: done_d = 1'b1;
            OpLoad: begin
              data_d = data_in;
              done_d = 1'b1;
            end
            OpClr: begin
              data_d = '0;
              done_d = 1'b1;
            end
            OpShl, OpShr, OpRol, OpRor, OpAsr: begin
              if (amt == '0) begin
                done_d = 1'b1;
              end else begin
                op_d    = op;
                cnt_d   = amt;
                state_d = StShift;
              end
            end
          endcase
        end
      end
      StShift: begin
        data_d = step(op_q, data_q, dbit);
        cnt_d  = cnt_q - AW'(1);
        if (cnt_q == AW'(1)) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    data_out = data_q;
    busy     = (state_q == StShift);
    done     = done_q;
  end

`ifdef USR_SEQ_CARRY_EN
  logic carry_q, carry_d;

  // Captures the bit leaving the register on each step; load and sync clear zero it.
  always_comb begin
    carry_d = carry_q;
    if (state_q == StShift) begin
      carry_d = (op_q == OpShl || op_q == OpRol) ? data_q[N-1] : data_q[0];
    end else if (start && (op == OpLoad || op == OpClr)) begin
      carry_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) carry_q <= 1'b0;
    else     carry_q <= carry_d;
  end

  assign carry = carry_q;
`endif

endmodule
